display_read_arbiter: RTL
=========================

# display_read_arbiter

Shares the memMux back-door read port (26-bit cache-line address, two 96-bit data beats per line) between the display controller's frame-buffer DMA and a secondary client (block copier / cursor fetcher). Grants one read at a time, records the owner of each accepted read in an in-order tag FIFO, and steers the returned data strobes to that owner. The display has fixed priority because it is the real-time client. Sits between the display controller / copier and memMux.

## Interface
- DEPTH, 8: maximum outstanding (acknowledged, not fully returned) reads; power of two, 2..32.
- BEATS, 2: RDready beats returned per read.
- MAX_RUN, 16: consecutive display grants allowed while the copier waits (DRA_FAIR_EN only).

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dReq  in  1  display read request; held with dRA until dAck
- dRA  in  26  display cache-line address
- dAck  out  1  one-cycle pulse: display request accepted by memory
- dRDready  out  1  current mRD beat belongs to display
- cReq  in  1  copier read request; held with cRA until cAck
- cRA  in  26  copier cache-line address
- cAck  out  1  one-cycle pulse: copier request accepted
- cRDready  out  1  current mRD beat belongs to copier
- mReq  out  1  registered request to memMux
- mRA  out  26  registered address to memMux
- mAck  in  1  memMux accepted mReq/mRA
- mRDready  in  1  memMux data beat valid (data bus routed externally to both clients)
- inFlight  out  log2(DEPTH)+1  outstanding read count
- orphan  out  1  sticky: beat arrived with no outstanding read

## Operation
- FSM states IDLE, ISSUE.
- IDLE: if (dReq | cReq) and inFlight < DEPTH, pick the winner, latch address into mRA, owner into `own`, assert mReq, go to ISSUE. Otherwise stay.
- Winner: display if dReq, else copier (see Configuration).
- ISSUE: mReq and mRA are held stable. On mAck: pulse dAck or cAck, selected by `own`, in the same cycle; push `own` into the tag FIFO; deassert mReq next cycle; go to IDLE.
- Clients must hold req/address until ack. A request is committed once latched, so its ack is delivered even if req has since dropped.
- Return path: on mRDready, dRDready = (head == D) and cRDready = (head == C), both combinational from mRDready. A beat counter counts to BEATS, then pops the head and clears.
- mRDready with the tag FIFO empty: no strobe to either client; orphan is set and held until reset.
- inFlight: +1 on push, -1 on pop, unchanged on simultaneous push and pop. No grant while inFlight == DEPTH. A pop in the same cycle does not enable the grant until the next cycle.
- Reset: state IDLE; tag FIFO emptied; beat counter 0; mReq=0, mRA=0, dAck=cAck=0, dRDready=cRDready=0, inFlight=0, orphan=0.
- Reset mid-operation: in-flight reads are forgotten. Beats arriving afterwards count as orphans; the display controller's post-frame flush window tolerates this.

## Timing
- Request to mReq: 1 cycle (grant in cycle N, mReq high in N+1).
- mAck to client ack: 0 cycles (combinational).
- Minimum issue interval: 2 cycles per read (IDLE, ISSUE).
- mRDready to client RDready: 0 cycles. No data buffering inside the block.
- Pop takes effect on the clock edge after the final beat. A beat on the next cycle already sees the new head.

## Configuration
- DRA_FAIR_EN defined: a run counter counts consecutive display grants made while cReq is high.
  - When the counter reaches MAX_RUN, the next grant goes to the copier if cReq is high.
  - The counter clears on any copier grant, or on a display grant with cReq low.
- DRA_FAIR_EN undefined: strict display priority; the copier is served only when dReq is low. No run counter exists.

## Test plan
- Single display read, addr 0x1000000, mAck after 3 cycles, then two mRDready beats: mRA=0x1000000; dAck pulses once with mAck; dRDready on both beats; cRDready never; inFlight goes 0→1→0.
- dReq and cReq asserted in the same cycle, both held: display is granted first. With DRA_FAIR_EN undefined and dReq held continuously, cAck never occurs.
- DRA_FAIR_EN, MAX_RUN=4, dReq and cReq held: grant order is D,D,D,D,C,D,D,D,D,C.
- DEPTH=8, immediate mAck, no returns: exactly 8 acks, then mReq stays low. After one read's final beat, the next grant occurs the following cycle.
- Interleaved owners D,C,D returning 6 beats back-to-back: strobes go D,D,C,C,D,D. A 7th beat sets orphan with no strobe.
- Reset asserted in ISSUE with 3 reads outstanding: next cycle mReq=0, inFlight=0. Subsequent mRDready sets orphan.

Source files
------------

// File: rtl/display_read_arbiter_if.sv
// Bus bundle between display_read_arbiter and its clients / memMux back-door read port.
// slave: the arbiter's view; master: the surrounding clients and memory.
interface display_read_arbiter_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              dReq;
  logic [ADDR_W-1:0] dRA;
  logic              dAck;
  logic              dRDready;
  logic              cReq;
  logic [ADDR_W-1:0] cRA;
  logic              cAck;
  logic              cRDready;
  logic              mReq;
  logic [ADDR_W-1:0] mRA;
  logic              mAck;
  logic              mRDready;
  logic [CNT_W-1:0]  inFlight;
  logic              orphan;

  modport slave (
    input  dReq, dRA, cReq, cRA, mAck, mRDready,
    output dAck, dRDready, cAck, cRDready, mReq, mRA, inFlight, orphan
  );

  modport master (
    output dReq, dRA, cReq, cRA, mAck, mRDready,
    input  dAck, dRDready, cAck, cRDready, mReq, mRA, inFlight, orphan
  );
endinterface

// File: rtl/display_read_arbiter.sv
// Shares the memMux back-door read port between display DMA (priority) and the copier.
// Optional macro DRA_FAIR_EN: bounds display runs to MAX_RUN grants while the copier waits.
module display_read_arbiter #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned BEATS   = 2,
  parameter int unsigned MAX_RUN = 16
) (
  input logic                  clock,
  input logic                  reset,
  display_read_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (DEPTH < 2 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("display_read_arbiter: DEPTH must be a power of two in 2..32");
  end
  if (BEATS < 1 || MAX_RUN < 1) begin : g_bad_cfg
    $error("display_read_arbiter: BEATS and MAX_RUN must be at least 1");
  end

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic                mreq_q, mreq_d;
  logic [ADDR_W-1:0]   mra_q, mra_d;
  logic                own_q, own_d;      // 1 = copier owns the pending read
  logic [DEPTH-1:0]    tag_q;             // in-order owner tags, 1 = copier
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                orphan_q, orphan_d;

  logic empty_c, beat_c, ack_c, pop_c, last_c, head_c, grant_c, pick_copier_c;

`ifdef DRA_FAIR_EN
  localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);
  logic [RUN_W-1:0] run_q, run_d;
  assign pick_copier_c = bus.cReq & (~bus.dReq | (run_q >= RUN_W'(MAX_RUN)));
`else
  assign pick_copier_c = ~bus.dReq;
`endif

  // Strobes are gated by reset so nothing leaks to clients during the reset cycle.
  assign empty_c = (cnt_q == '0);
  assign beat_c  = bus.mRDready & ~reset;
  assign ack_c   = (state_q == ISSUE) & bus.mAck & ~reset;
  assign head_c  = tag_q[rptr_q];
  assign last_c  = (beat_q == BEAT_W'(BEATS - 1));
  assign pop_c   = beat_c & ~empty_c & last_c;
  assign grant_c = (state_q == IDLE) & (bus.dReq | bus.cReq) & (cnt_q < CNT_W'(DEPTH));

  assign bus.dAck     = ack_c & ~own_q;
  assign bus.cAck     = ack_c & own_q;
  assign bus.dRDready = beat_c & ~empty_c & ~head_c;
  assign bus.cRDready = beat_c & ~empty_c & head_c;
  assign bus.mReq     = mreq_q;
  assign bus.mRA      = mra_q;
  assign bus.inFlight = cnt_q;
  assign bus.orphan   = orphan_q;

  // Next-state: issue FSM, tag FIFO pointers, beat counter, sticky orphan.
  always_comb begin
    state_d  = state_q;
    mreq_d   = mreq_q;
    mra_d    = mra_q;
    own_d    = own_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    orphan_d = orphan_q | (beat_c & empty_c);
`ifdef DRA_FAIR_EN
    run_d    = run_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_c) begin
          state_d = ISSUE;
          mreq_d  = 1'b1;
          own_d   = pick_copier_c;
          mra_d   = pick_copier_c ? bus.cRA : bus.dRA;
`ifdef DRA_FAIR_EN
          if (pick_copier_c || !bus.cReq) run_d = '0;
          else                            run_d = run_q + RUN_W'(1);
`endif
        end
      end
      ISSUE: begin
        if (bus.mAck) begin
          state_d = IDLE;
          mreq_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ack_c) wptr_d = wptr_q + PTR_W'(1);
    if (pop_c) rptr_d = rptr_q + PTR_W'(1);

    case ({ack_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (beat_c && !empty_c) beat_d = last_c ? '0 : beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mra_q    <= '0;
      own_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      orphan_q <= 1'b0;
`ifdef DRA_FAIR_EN
      run_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mra_q    <= mra_d;
      own_q    <= own_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      orphan_q <= orphan_d;
`ifdef DRA_FAIR_EN
      run_q    <= run_d;
`endif
    end
  end

  // Tag storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (ack_c) tag_q[wptr_q] <= own_q;
  end
endmodule
